// File: rtl/fetch_entry_queue.sv
// Elastic FIFO of fetch entries in front of the ID stage; halts after a faulting fetch until flush.
// Optional combinational empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.

package config_pkg;
    typedef struct packed {
        int unsigned xlen;
        int unsigned vlen;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

package ariane_pkg;
    typedef struct packed {
        logic [31:0] tval;
        logic [3:0]  cause;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] instruction;
        exception_t  ex;
    } fetch_entry_t;
endpackage

// state  | meaning
// ACCEPT | taking new entries while not full
// HALTED | faulting fetch queued; refuse input, keep draining until flush
module fetch_entry_queue #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  ariane_pkg::fetch_entry_t fetch_entry_i,
    input  logic                     fetch_entry_valid_i,
    output logic                     fetch_entry_ready_o,
    output ariane_pkg::fetch_entry_t fetch_entry_o,
    output logic                     fetch_entry_valid_o,
    input  logic                     fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {
        ACCEPT = 1'b0,
        HALTED = 1'b1
    } state_e;

    state_e                   state_q;
    logic [CntW-1:0]          cnt_q;
    logic [PtrW-1:0]          rptr_q;
    logic [PtrW-1:0]          wptr_q;
    ariane_pkg::fetch_entry_t mem_q [DEPTH];

    logic push;
    logic push_store;
    logic pop_store;
    logic bypass_take;
    logic unused_cfg;

    assign unused_cfg = ^CVA6Cfg;

    // Readiness depends only on registered state and flush, never on the downstream ready.
    assign fetch_entry_ready_o = (cnt_q != CntW'(DEPTH)) && (state_q == ACCEPT) && !flush_i;
    assign push                = fetch_entry_valid_i && fetch_entry_ready_o;
    assign count_o             = cnt_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_sel;
    assign bypass_sel          = (cnt_q == '0) && (state_q == ACCEPT);
    assign fetch_entry_valid_o = bypass_sel ? (fetch_entry_valid_i && !flush_i) : (cnt_q != '0);
    assign fetch_entry_o       = bypass_sel ? fetch_entry_i : mem_q[rptr_q];
    assign bypass_take         = bypass_sel && push && fetch_entry_ready_i;
`else
    assign fetch_entry_valid_o = (cnt_q != '0);
    assign fetch_entry_o       = mem_q[rptr_q];
    assign bypass_take         = 1'b0;
`endif

    // An entry consumed through the bypass is never written into storage.
    assign push_store = push && !bypass_take;
    assign pop_store  = (cnt_q != '0) && fetch_entry_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACCEPT;
            cnt_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            state_q <= ACCEPT;
            cnt_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
        end else begin
            if (push_store) begin
                mem_q[wptr_q] <= fetch_entry_i;
                wptr_q        <= wptr_q + PtrW'(1);
            end
            if (pop_store) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            unique case ({push_store, pop_store})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (push && fetch_entry_i.ex.valid) begin
                state_q <= HALTED;
            end
        end
    end

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Scoreboard bench for fetch_entry_queue: stimulus queues expected entries, a negedge monitor checks pops.
`timescale 1ns/1ps

module tb_fetch_entry_queue;

    typedef ariane_pkg::fetch_entry_t fe_t;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    fe_t        fetch_entry_i;
    logic       fetch_entry_valid_i;
    logic       fetch_entry_ready_o;
    fe_t        fetch_entry_o;
    logic       fetch_entry_valid_o;
    logic       fetch_entry_ready_i;
    logic [2:0] count_o;

    int checks = 0;
    int errors = 0;
    fe_t sb[$];

    fetch_entry_queue #(.DEPTH(4)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .fetch_entry_i       (fetch_entry_i),
        .fetch_entry_valid_i (fetch_entry_valid_i),
        .fetch_entry_ready_o (fetch_entry_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i),
        .count_o             (count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic fe_t mk(input logic [31:0] addr, input logic exv);
        fe_t e;
        e             = '0;
        e.address     = addr;
        e.instruction = addr ^ 32'h0000_0013;
        e.ex.valid    = exv;
        e.ex.cause    = exv ? 4'd1 : 4'd0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one entry for one cycle; exp_acc is the hand-derived acceptance.
    task automatic drive(input fe_t e, input logic exp_acc);
        fetch_entry_i       = e;
        fetch_entry_valid_i = 1'b1;
        #1;
        chk("push_ready", fetch_entry_ready_o, exp_acc);
        if (exp_acc) sb.push_back(e);
        tick();
        fetch_entry_valid_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && fetch_entry_valid_o && fetch_entry_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop actual=%0h required=none", fetch_entry_o);
            end else begin
                chk("pop_data", fetch_entry_o, sb.pop_front());
            end
        end
    end

    initial begin
        rst_ni              = 1'b0;
        flush_i             = 1'b0;
        fetch_entry_i       = '0;
        fetch_entry_valid_i = 1'b0;
        fetch_entry_ready_i = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;
        #1;
        chk("rst_valid", fetch_entry_valid_o, 1'b0);
        chk("rst_ready", fetch_entry_ready_o, 1'b1);
        chk("rst_count", count_o, 3'd0);
        chk("rst_entry", fetch_entry_o, '0);
        tick();

        // fill to full, then drain in order
        for (int k = 0; k < 4; k++) drive(mk(32'h8000_0000 + 32'(4 * k), 1'b0), 1'b1);
        chk("full_count", count_o, 3'd4);
        chk("full_ready", fetch_entry_ready_o, 1'b0);
        fetch_entry_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("drain_count", count_o, 3'(4 - k));
        end
        fetch_entry_ready_i = 1'b0;
        chk("drain_sb_empty", sb.size(), 0);

        // streaming across pointer wrap
        drive(mk(32'h2000, 1'b0), 1'b1);
        fetch_entry_ready_i = 1'b1;
        for (int k = 1; k < 10; k++) begin
            drive(mk(32'h2000 + 32'(4 * k), 1'b0), 1'b1);
            chk("stream_count", count_o, 3'd1);
        end
        tick();
        chk("stream_end_count", count_o, 3'd0);
        fetch_entry_ready_i = 1'b0;

        // faulting fetch halts acceptance
        drive(mk(32'h3000, 1'b0), 1'b1);
        drive(mk(32'h3004, 1'b1), 1'b1);
        drive(mk(32'h3008, 1'b0), 1'b0);
        chk("halt_count", count_o, 3'd2);
        fetch_entry_ready_i = 1'b1;
        tick();
        tick();
        chk("halt_drained", count_o, 3'd0);
        chk("halt_ready", fetch_entry_ready_o, 1'b0);
        fetch_entry_ready_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        chk("unhalt_ready", fetch_entry_ready_o, 1'b1);
        chk("unhalt_count", count_o, 3'd0);

        // flush with a simultaneous push
        for (int k = 0; k < 3; k++) drive(mk(32'h4000 + 32'(4 * k), 1'b0), 1'b1);
        chk("preflush_count", count_o, 3'd3);
        flush_i             = 1'b1;
        fetch_entry_i       = mk(32'h4FF0, 1'b0);
        fetch_entry_valid_i = 1'b1;
        #1;
        chk("flush_ready", fetch_entry_ready_o, 1'b0);
        tick();
        flush_i             = 1'b0;
        fetch_entry_valid_i = 1'b0;
        sb.delete();
        chk("flush_count", count_o, 3'd0);
        chk("flush_valid", fetch_entry_valid_o, 1'b0);
        fetch_entry_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("postflush_valid", fetch_entry_valid_o, 1'b0);
        end
        fetch_entry_ready_i = 1'b0;

        // asynchronous reset mid-stream
        drive(mk(32'h5000, 1'b0), 1'b1);
        drive(mk(32'h5004, 1'b0), 1'b1);
        chk("prerst_count", count_o, 3'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", fetch_entry_valid_o, 1'b0);
        chk("arst_count", count_o, 3'd0);
        chk("arst_entry", fetch_entry_o, '0);
        sb.delete();
        tick();
        rst_ni = 1'b1;
        tick();
        drive(mk(32'h5100, 1'b0), 1'b1);
        chk("rst_first_valid", fetch_entry_valid_o, 1'b1);
        chk("rst_first_entry", fetch_entry_o, mk(32'h5100, 1'b0));
        chk("rst_first_count", count_o, 3'd1);
        fetch_entry_ready_i = 1'b1;
        tick();
        fetch_entry_ready_i = 1'b0;
        chk("rst_drain_count", count_o, 3'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
        // zero-latency bypass on an empty queue
        fetch_entry_ready_i = 1'b1;
        fetch_entry_i       = mk(32'h1000, 1'b0);
        fetch_entry_valid_i = 1'b1;
        #1;
        chk("byp_valid", fetch_entry_valid_o, 1'b1);
        chk("byp_addr", fetch_entry_o.address, 32'h1000);
        sb.push_back(mk(32'h1000, 1'b0));
        tick();
        fetch_entry_valid_i = 1'b0;
        fetch_entry_ready_i = 1'b0;
        chk("byp_count", count_o, 3'd0);
`endif

        tick();
        chk("sb_empty_end", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_entry_queue.md
# fetch_entry_queue

Elastic FIFO of decoded-ready fetch entries sitting directly upstream of the ID stage: accepts `ariane_pkg::fetch_entry_t` entries from the frontend with a valid/ready handshake and presents them in order to the ID stage's `fetch_entry_i` / `fetch_entry_valid_i` / `fetch_entry_ready_o` port. It decouples frontend stalls from ID back-pressure, drops everything on a pipeline flush, and stops accepting after queuing a faulting fetch, because that fetch is guaranteed to cause a flush.

## Interface
Parameters:
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration, passed through for type sizing.
- `DEPTH`, default 4: number of entries; a power of two, at least 2.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  drop all queued entries and leave HALTED.
- `fetch_entry_i`  in  `$bits(ariane_pkg::fetch_entry_t)`  entry from the frontend.
- `fetch_entry_valid_i`  in  1  frontend entry valid.
- `fetch_entry_ready_o`  out  1  queue accepts this cycle.
- `fetch_entry_o`  out  `$bits(ariane_pkg::fetch_entry_t)`  head entry to ID.
- `fetch_entry_valid_o`  out  1  head valid.
- `fetch_entry_ready_i`  in  1  ID acknowledges the head.
- `count_o`  out  `$clog2(DEPTH)+1`  current occupancy.

## Operation
- Storage: `DEPTH`-entry array, read pointer `rptr`, write pointer `wptr` (each `$clog2(DEPTH)` bits, wrapping modulo DEPTH), counter `cnt` in the range 0..DEPTH.
- Push: `fetch_entry_valid_i && fetch_entry_ready_o`. Writes to `wptr`, then `wptr++`.
- Pop: `fetch_entry_valid_o && fetch_entry_ready_i`. Then `rptr++`.
- `cnt_n = cnt + push - pop`. A simultaneous push and pop leaves `cnt` unchanged.
- `fetch_entry_ready_o = (cnt != DEPTH) && (state == ACCEPT) && !flush_i`.
  - There is no combinational path from `fetch_entry_ready_i` to `fetch_entry_ready_o`.
  - When the queue is full, a pop in the same cycle does not enable a push.
- `fetch_entry_valid_o = (cnt != 0)`, with the bypass exception in Configuration. `fetch_entry_o = mem[rptr]`.
- FSM with two states:
  - ACCEPT → HALTED on a push whose `fetch_entry_i.ex.valid == 1`. That entry is stored and is still delivered downstream.
  - HALTED → ACCEPT only on `flush_i`.
  - In HALTED, `fetch_entry_ready_o = 0`. Queued entries continue to drain.
- Flush, which has priority over everything else:
  - `cnt`, `rptr` and `wptr` go to 0; state goes to ACCEPT.
  - A push in the flush cycle is discarded; `fetch_entry_ready_o` is already low.
  - A pop in the flush cycle has no effect beyond the reset of the pointers.
- A pop while empty cannot occur, because valid is low. A push while full cannot occur, because ready is low.

## Timing
- Reset values: `fetch_entry_valid_o = 0`, `fetch_entry_ready_o = 1`, `count_o = 0`, `fetch_entry_o = '0`. All storage is cleared; state is ACCEPT.
- Registered-path latency: an entry pushed in cycle N is visible on `fetch_entry_o` with valid high in cycle N+1, provided the queue was empty. Otherwise it is visible after the older entries drain.
- Steady-state throughput: 1 push and 1 pop per cycle while `0 < cnt < DEPTH`.
- `count_o` reflects the registered `cnt`, i.e. the value after the previous edge.
- Flush at edge N: `fetch_entry_valid_o = 0` and `count_o = 0` from cycle N+1. `fetch_entry_ready_o` returns to 1 in cycle N+1.
- Reset asserted mid-operation: all state returns to reset values asynchronously. No partial entries survive.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When `cnt == 0` and state is ACCEPT, `fetch_entry_valid_o = fetch_entry_valid_i && !flush_i` and `fetch_entry_o = fetch_entry_i`, combinationally.
  - If `fetch_entry_ready_i` is high in that same cycle, the entry is consumed and never written: `cnt` stays 0 and the pointers are unchanged.
  - HALTED transition rules are unchanged for bypassed entries, i.e. a bypassed entry with `ex.valid` still enters HALTED.
  - Zero-cycle latency when empty.
- Not defined: no bypass; minimum latency is 1 cycle as described in Timing.

## Test plan
- Fill to full: push 4 entries with addresses 0x80000000, +4, +8, +C and `fetch_entry_ready_i = 0`.
  - Required: `count_o = 4` and `fetch_entry_ready_o = 0` after the 4th push.
  - Raising `fetch_entry_ready_i` then pops the entries in order; `count_o` steps 3, 2, 1, 0.
- Streaming with wrap: continuous push and pop for 10 entries with `DEPTH = 4`.
  - Required: `count_o` stays at 1 once steady, outputs appear in order, and the pointers wrap without loss or duplication.
- Exception halt: the 2nd of 3 pushes carries `ex.valid = 1`.
  - Required: the 3rd is refused (`fetch_entry_ready_o = 0` the next cycle) and the 2 stored entries drain.
  - Required: the queue stays HALTED until `flush_i` pulses, then `fetch_entry_ready_o = 1`.
- Flush with a simultaneous push: `cnt = 3`, `flush_i = 1` and `fetch_entry_valid_i = 1` in the same cycle.
  - Required: next cycle `count_o = 0` and `fetch_entry_valid_o = 0`, and the pushed entry never appears.
- Reset mid-stream: assert `rst_ni = 0` with `cnt = 2`.
  - Required: `fetch_entry_valid_o` drops immediately and `count_o = 0`.
  - Required: after release, the first new push is output first.
- Bypass (with `FETCH_QUEUE_BYPASS_EN`): queue empty, push address 0x1000 with `fetch_entry_ready_i = 1`.
  - Required: same cycle, `fetch_entry_valid_o = 1` and `fetch_entry_o.address = 0x1000`; next cycle `count_o = 0`.
